// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between the writeback stage and a
// FIFO-buffered auxiliary return path, with starvation relief and a busy scoreboard.
module regfile_wr_arbiter #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wb_we,
  input  logic [3:0]                 i_wb_wa,
  input  logic [WIDTH-1:0]           i_wb_wd,
  input  logic                       i_aux_valid,
  output logic                       o_aux_ready,
  input  logic [3:0]                 i_aux_wa,
  input  logic [WIDTH-1:0]           i_aux_wd,
  input  logic                       i_iss_valid,
  input  logic [3:0]                 i_iss_wa,
  output logic [15:0]                o_busy,
  output logic                       o_stall,
  output logic [$clog2(DEPTH):0]     o_fifo_cnt,
  output logic                       o_rf_we,
  output logic [3:0]                 o_rf_wa,
  output logic [WIDTH-1:0]           o_rf_wd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  logic [3:0]       r_mem_wa [DEPTH];
  logic [WIDTH-1:0] r_mem_wd [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic [SW-1:0]    r_starve;
  logic             r_stall;
  logic             r_rf_we;
  logic [3:0]       r_rf_wa;
  logic [WIDTH-1:0] r_rf_wd;
  logic [15:0]      r_busy;

  logic             w_fifo_empty;
  logic             w_push;
  logic             w_aux_gnt;
  logic             w_wb_gnt;
  logic [3:0]       w_gnt_wa;
  logic [WIDTH-1:0] w_gnt_wd;
  logic [15:0]      w_set_mask;
  logic [15:0]      w_clr_mask;
  logic [15:0]      w_busy_nxt;

  assign w_fifo_empty = (r_cnt == {CW{1'b0}});
  assign o_aux_ready  = (r_cnt != CW'(DEPTH));
  assign w_push       = i_aux_valid && o_aux_ready;

  // A forced stall lets the FIFO head through; otherwise WB has priority.
  always_comb begin
    w_aux_gnt = 1'b0;
    w_wb_gnt  = 1'b0;
    w_gnt_wa  = 4'h0;
    w_gnt_wd  = {WIDTH{1'b0}};
    if (r_stall && !w_fifo_empty) begin
      w_aux_gnt = 1'b1;
      w_gnt_wa  = r_mem_wa[r_rd_ptr];
      w_gnt_wd  = r_mem_wd[r_rd_ptr];
    end else if (i_wb_we) begin
      w_wb_gnt  = 1'b1;
      w_gnt_wa  = i_wb_wa;
      w_gnt_wd  = i_wb_wd;
    end else if (!w_fifo_empty) begin
      w_aux_gnt = 1'b1;
      w_gnt_wa  = r_mem_wa[r_rd_ptr];
      w_gnt_wd  = r_mem_wd[r_rd_ptr];
    end else begin
      w_aux_gnt = 1'b0;
      w_wb_gnt  = 1'b0;
    end
  end

  // Aux FIFO storage, pointers and occupancy; no bypass, so a push is poppable next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_wa[i] <= 4'h0;
        r_mem_wd[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem_wa[r_wr_ptr] <= i_aux_wa;
        r_mem_wd[r_wr_ptr] <= i_aux_wd;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_aux_gnt) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_aux_gnt})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Starvation counter: every STARVE_LIMIT-th WB win over a waiting aux entry forces a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= {SW{1'b0}};
      r_stall  <= 1'b0;
    end else if (w_wb_gnt && !w_fifo_empty) begin
      if (r_starve == SW'(STARVE_LIMIT - 1)) begin
        r_starve <= {SW{1'b0}};
        r_stall  <= 1'b1;
      end else begin
        r_starve <= r_starve + 1'b1;
        r_stall  <= 1'b0;
      end
    end else begin
      r_starve <= {SW{1'b0}};
      r_stall  <= 1'b0;
    end
  end

  // Registered write port; an r0 destination still consumes the slot but never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we <= 1'b0;
      r_rf_wa <= 4'h0;
      r_rf_wd <= {WIDTH{1'b0}};
    end else begin
      r_rf_we <= (w_aux_gnt || w_wb_gnt) && (w_gnt_wa != 4'h0);
      if (w_aux_gnt || w_wb_gnt) begin
        r_rf_wa <= w_gnt_wa;
        r_rf_wd <= w_gnt_wd;
      end
    end
  end

  // The clear lands on the same edge that raises rf_we for the aux write; a set then wins.
  assign w_clr_mask = (w_aux_gnt && (w_gnt_wa != 4'h0)) ? (16'h0001 << w_gnt_wa) : 16'h0000;
  assign w_set_mask = (i_iss_valid && (i_iss_wa != 4'h0)) ? (16'h0001 << i_iss_wa) : 16'h0000;
  assign w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & 16'hFFFE;

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 16'h0000;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_stall    = r_stall;
  assign o_fifo_cnt = r_cnt;
  assign o_rf_we    = r_rf_we;
  assign o_rf_wa    = r_rf_wa;
  assign o_rf_wd    = r_rf_wd;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter (WIDTH=8, DEPTH=2, STARVE_LIMIT=4).
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_we;
  logic [3:0]  wb_wa;
  logic [7:0]  wb_wd;
  logic        aux_valid;
  logic        aux_ready;
  logic [3:0]  aux_wa;
  logic [7:0]  aux_wd;
  logic        iss_valid;
  logic [3:0]  iss_wa;
  logic [15:0] busy;
  logic        stall;
  logic [1:0]  fifo_cnt;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [7:0]  rf_wd;

  int pass_cnt = 0;
  int total_cnt = 0;

  regfile_wr_arbiter #(.WIDTH(8), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_we(wb_we), .i_wb_wa(wb_wa), .i_wb_wd(wb_wd),
    .i_aux_valid(aux_valid), .o_aux_ready(aux_ready), .i_aux_wa(aux_wa), .i_aux_wd(aux_wd),
    .i_iss_valid(iss_valid), .i_iss_wa(iss_wa),
    .o_busy(busy), .o_stall(stall), .o_fifo_cnt(fifo_cnt),
    .o_rf_we(rf_we), .o_rf_wa(rf_wa), .o_rf_wd(rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_wa = 4'h0; wb_wd = 8'h00;
    aux_valid = 1'b0; aux_wa = 4'h0; aux_wd = 8'h00;
    iss_valid = 1'b0; iss_wa = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_we = 1'($urandom); wb_wa = 4'($urandom); wb_wd = 8'($urandom);
      aux_valid = 1'($urandom); aux_wa = 4'($urandom); aux_wd = 8'($urandom);
      iss_valid = 1'($urandom); iss_wa = 4'($urandom);
      tick();
    end
    total_cnt++; if (busy !== 16'h0000) $display("FAIL rst_busy: got %h expected 0000", busy); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b expected 0", stall); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL rst_rf_we: got %b expected 0", rf_we); else pass_cnt++;
    total_cnt++; if (aux_ready !== 1'b1) $display("FAIL rst_aux_ready: got %b expected 1", aux_ready); else pass_cnt++;
    total_cnt++; if (fifo_cnt !== 2'd0) $display("FAIL rst_fifo_cnt: got %0d expected 0", fifo_cnt); else pass_cnt++;
    idle();
    rst_n = 1'b1;
    tick();
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL rel_rf_we: got %b expected 0", rf_we); else pass_cnt++;
    total_cnt++; if (fifo_cnt !== 2'd0) $display("FAIL rel_fifo_cnt: got %0d expected 0", fifo_cnt); else pass_cnt++;
    total_cnt++; if ({rf_wa, rf_wd} !== 12'h000) $display("FAIL rel_rf_wa_wd: got %h expected 000", {rf_wa, rf_wd}); else pass_cnt++;
  endtask

  task automatic test_aux_only();
    aux_valid = 1'b1; aux_wa = 4'd5; aux_wd = 8'h3C;
    tick();
    aux_valid = 1'b0;
    total_cnt++; if (fifo_cnt !== 2'd1) $display("FAIL aux_cnt_push: got %0d expected 1", fifo_cnt); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL aux_no_bypass: got %b expected 0", rf_we); else pass_cnt++;
    tick();
    total_cnt++; if (rf_we !== 1'b1) $display("FAIL aux_rf_we: got %b expected 1", rf_we); else pass_cnt++;
    total_cnt++; if (rf_wa !== 4'd5) $display("FAIL aux_rf_wa: got %0d expected 5", rf_wa); else pass_cnt++;
    total_cnt++; if (rf_wd !== 8'h3C) $display("FAIL aux_rf_wd: got %h expected 3c", rf_wd); else pass_cnt++;
    total_cnt++; if (fifo_cnt !== 2'd0) $display("FAIL aux_cnt_pop: got %0d expected 0", fifo_cnt); else pass_cnt++;
    tick();
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL aux_idle_we: got %b expected 0", rf_we); else pass_cnt++;
  endtask

  task automatic test_priority();
    wb_we = 1'b1; wb_wa = 4'd1; wb_wd = 8'h10;
    aux_valid = 1'b1; aux_wa = 4'd2; aux_wd = 8'h11;
    tick();
    total_cnt++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd1, 8'h10}) $display("FAIL pri_wb_first: got %h expected 110", {rf_we, rf_wa, rf_wd}); else pass_cnt++;
    total_cnt++; if (aux_ready !== 1'b1) $display("FAIL pri_ready1: got %b expected 1", aux_ready); else pass_cnt++;
    aux_wa = 4'd3; aux_wd = 8'h22;
    tick();
    total_cnt++; if (fifo_cnt !== 2'd2) $display("FAIL pri_full_cnt: got %0d expected 2", fifo_cnt); else pass_cnt++;
    total_cnt++; if (aux_ready !== 1'b0) $display("FAIL pri_full_ready: got %b expected 0", aux_ready); else pass_cnt++;
    aux_wa = 4'd4; aux_wd = 8'h33;
    tick();
    total_cnt++; if (fifo_cnt !== 2'd2) $display("FAIL pri_third_blocked: got %0d expected 2", fifo_cnt); else pass_cnt++;
    total_cnt++; if (rf_wa !== 4'd1) $display("FAIL pri_wb_holds: got %0d expected 1", rf_wa); else pass_cnt++;
    wb_we = 1'b0;
    tick();
    total_cnt++; if (fifo_cnt !== 2'd1) $display("FAIL pri_full_pop_no_push: got %0d expected 1", fifo_cnt); else pass_cnt++;
    total_cnt++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd2, 8'h11}) $display("FAIL pri_pop1: got %h expected 211", {rf_we, rf_wa, rf_wd}); else pass_cnt++;
    tick();
    aux_valid = 1'b0;
    total_cnt++; if (fifo_cnt !== 2'd1) $display("FAIL pri_push_pop_cnt: got %0d expected 1", fifo_cnt); else pass_cnt++;
    total_cnt++; if ({rf_wa, rf_wd} !== {4'd3, 8'h22}) $display("FAIL pri_pop2: got %h expected 322", {rf_wa, rf_wd}); else pass_cnt++;
    tick();
    total_cnt++; if ({rf_wa, rf_wd} !== {4'd4, 8'h33}) $display("FAIL pri_pop3: got %h expected 433", {rf_wa, rf_wd}); else pass_cnt++;
    total_cnt++; if (fifo_cnt !== 2'd0) $display("FAIL pri_drained: got %0d expected 0", fifo_cnt); else pass_cnt++;
  endtask

  task automatic test_starvation();
    idle();
    aux_valid = 1'b1; aux_wa = 4'd7; aux_wd = 8'hAA;
    tick();
    aux_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      wb_we = 1'b1; wb_wa = 4'd8; wb_wd = 8'h80 + 8'(k);
      tick();
      total_cnt++; if (stall !== ((k == 4) ? 1'b1 : 1'b0)) $display("FAIL starve_stall_k%0d: got %b expected %b", k, stall, (k == 4)); else pass_cnt++;
      total_cnt++; if (rf_wd !== 8'h80 + 8'(k)) $display("FAIL starve_wb_k%0d: got %h expected %h", k, rf_wd, 8'h80 + 8'(k)); else pass_cnt++;
    end
    wb_wd = 8'h85;
    tick();
    total_cnt++; if (stall !== 1'b0) $display("FAIL starve_stall_drop: got %b expected 0", stall); else pass_cnt++;
    total_cnt++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd7, 8'hAA}) $display("FAIL starve_aux_win: got %h expected 17aa", {rf_we, rf_wa, rf_wd}); else pass_cnt++;
    total_cnt++; if (fifo_cnt !== 2'd0) $display("FAIL starve_cnt: got %0d expected 0", fifo_cnt); else pass_cnt++;
    tick();
    total_cnt++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd8, 8'h85}) $display("FAIL starve_held_wb: got %h expected 1885", {rf_we, rf_wa, rf_wd}); else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_wa = 4'd9;
    tick();
    iss_valid = 1'b0;
    total_cnt++; if (busy !== 16'h0200) $display("FAIL sb_set: got %h expected 0200", busy); else pass_cnt++;
    aux_valid = 1'b1; aux_wa = 4'd9; aux_wd = 8'h55;
    tick();
    aux_valid = 1'b0;
    total_cnt++; if (busy !== 16'h0200) $display("FAIL sb_pending: got %h expected 0200", busy); else pass_cnt++;
    tick();
    total_cnt++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd9, 8'h55}) $display("FAIL sb_write: got %h expected 1955", {rf_we, rf_wa, rf_wd}); else pass_cnt++;
    total_cnt++; if (busy !== 16'h0000) $display("FAIL sb_clear: got %h expected 0000", busy); else pass_cnt++;
    iss_valid = 1'b1; iss_wa = 4'd9;
    aux_valid = 1'b1; aux_wa = 4'd9; aux_wd = 8'h66;
    tick();
    aux_valid = 1'b0;
    total_cnt++; if (busy !== 16'h0200) $display("FAIL sb_reset_bit: got %h expected 0200", busy); else pass_cnt++;
    tick();
    iss_valid = 1'b0;
    total_cnt++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd9, 8'h66}) $display("FAIL sb_write2: got %h expected 1966", {rf_we, rf_wa, rf_wd}); else pass_cnt++;
    total_cnt++; if (busy !== 16'h0200) $display("FAIL sb_set_wins: got %h expected 0200", busy); else pass_cnt++;
    iss_valid = 1'b1; iss_wa = 4'd0;
    wb_we = 1'b1; wb_wa = 4'd9; wb_wd = 8'h77;
    tick();
    idle();
    total_cnt++; if (busy !== 16'h0200) $display("FAIL sb_r0_wb_untouched: got %h expected 0200", busy); else pass_cnt++;
  endtask

  task automatic test_r0_reset();
    aux_valid = 1'b1; aux_wa = 4'd0; aux_wd = 8'hFF;
    tick();
    aux_valid = 1'b0;
    tick();
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL r0_no_we: got %b expected 0", rf_we); else pass_cnt++;
    total_cnt++; if ({rf_wa, rf_wd} !== {4'd0, 8'hFF}) $display("FAIL r0_slot: got %h expected 0ff", {rf_wa, rf_wd}); else pass_cnt++;
    total_cnt++; if (fifo_cnt !== 2'd0) $display("FAIL r0_popped: got %0d expected 0", fifo_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 16'h0200) $display("FAIL r0_busy: got %h expected 0200", busy); else pass_cnt++;
    iss_valid = 1'b1; iss_wa = 4'd4;
    tick();
    iss_valid = 1'b0;
    wb_we = 1'b1; wb_wa = 4'd1; wb_wd = 8'h10;
    aux_valid = 1'b1; aux_wa = 4'd10; aux_wd = 8'h01;
    tick();
    aux_wa = 4'd11; aux_wd = 8'h02;
    tick();
    aux_valid = 1'b0;
    total_cnt++; if (fifo_cnt !== 2'd2) $display("FAIL mid_pre_cnt: got %0d expected 2", fifo_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 16'h0210) $display("FAIL mid_pre_busy: got %h expected 0210", busy); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (fifo_cnt !== 2'd0) $display("FAIL mid_cnt: got %0d expected 0", fifo_cnt); else pass_cnt++;
    total_cnt++; if (busy !== 16'h0000) $display("FAIL mid_busy: got %h expected 0000", busy); else pass_cnt++;
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL mid_rf_we: got %b expected 0", rf_we); else pass_cnt++;
    total_cnt++; if (aux_ready !== 1'b1) $display("FAIL mid_ready: got %b expected 1", aux_ready); else pass_cnt++;
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL mid_discarded_we: got %b expected 0", rf_we); else pass_cnt++;
    total_cnt++; if (fifo_cnt !== 2'd0) $display("FAIL mid_discarded_cnt: got %0d expected 0", fifo_cnt); else pass_cnt++;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_aux_only();
    test_priority();
    test_starvation();
    test_scoreboard();
    test_r0_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
